// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data enable, pixel coordinates,
// lead-time fetch request, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 2,
  parameter int CW       = 12
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          req,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_OFS = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] VA_OFS = CW'(V_SYNC + V_BACK);
  localparam logic [CW:0]   HA_S   = (CW+1)'(H_SYNC + H_BACK);
  localparam logic [CW:0]   HA_E   = (CW+1)'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] VA_S   = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VA_E   = CW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CW:0]   LEAD   = (CW+1)'(REQ_LEAD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_h, r_v, w_h_nxt, w_v_nxt;
  logic          w_run_nxt;
  logic          w_h_last, w_v_last;

  logic          w_hs_nxt, w_vs_nxt, w_de_nxt, w_req_nxt, w_ls_nxt, w_fs_nxt;
  logic [CW-1:0] w_px_nxt, w_py_nxt;

  logic          r_hsync, r_vsync, r_de, r_req, r_ls, r_fs;
  logic [CW-1:0] r_px, r_py;
  logic [7:0]    r_frame_cnt;

  // Horizontal range test is one bit wider so the req look-ahead cannot wrap
  function automatic logic in_h_active(input logic [CW:0] x);
    return (x >= HA_S) && (x < HA_E);
  endfunction

  function automatic logic in_v_active(input logic [CW-1:0] y);
    return (y >= VA_S) && (y < VA_E);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    w_run_nxt   = 1'b0;
    w_h_last    = (r_h == H_LAST);
    w_v_last    = (r_v == V_LAST);
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_RUN;
          w_run_nxt   = 1'b1;
        end
      end
      default: begin
        if (w_h_last && w_v_last) begin
          w_h_nxt     = '0;
          w_v_nxt     = '0;
          w_run_nxt   = en;
          w_state_nxt = en ? S_RUN : S_IDLE;
        end else begin
          w_run_nxt   = 1'b1;
          w_state_nxt = en ? S_RUN : S_DRAIN;
          if (w_h_last) begin
            w_h_nxt = '0;
            w_v_nxt = r_v + CW'(1);
          end else begin
            w_h_nxt = r_h + CW'(1);
          end
        end
      end
    endcase
  end

  // Outputs decode the position being entered, so registered outputs match it
  always_comb begin
    w_hs_nxt  = (w_run_nxt && (w_h_nxt < HS_END)) ? HS_POL : ~HS_POL;
    w_vs_nxt  = (w_run_nxt && (w_v_nxt < VS_END)) ? VS_POL : ~VS_POL;
    w_de_nxt  = w_run_nxt && in_h_active({1'b0, w_h_nxt}) && in_v_active(w_v_nxt);
    w_req_nxt = w_run_nxt && in_h_active({1'b0, w_h_nxt} + LEAD) && in_v_active(w_v_nxt);
    w_ls_nxt  = w_run_nxt && (w_h_nxt == '0);
    w_fs_nxt  = w_ls_nxt && (w_v_nxt == '0);
    w_px_nxt  = w_de_nxt ? (w_h_nxt - HA_OFS) : '0;
    w_py_nxt  = w_de_nxt ? (w_v_nxt - VA_OFS) : '0;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_de        <= 1'b0;
      r_req       <= 1'b0;
      r_ls        <= 1'b0;
      r_fs        <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_hsync <= w_hs_nxt;
      r_vsync <= w_vs_nxt;
      r_de    <= w_de_nxt;
      r_req   <= w_req_nxt;
      r_ls    <= w_ls_nxt;
      r_fs    <= w_fs_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      if (w_fs_nxt) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign req         = r_req;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign pix_x       = r_px;
  assign pix_y       = r_py;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode, a tiny reparametrised mode and a long-lead mode.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default mode
  logic rst_a = 1'b1, en_a = 1'b0;
  logic hs_a, vs_a, de_a, req_a, ls_a, fs_a;
  logic [11:0] px_a, py_a;
  logic [7:0] fc_a;
  vga_timing_gen dut_a (
    .vga_clk(clk), .rst(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .pix_x(px_a), .pix_y(py_a), .req(req_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a));

  // Small mode: H 2/1/4/1, V 1/1/3/1, positive syncs
  logic rst_b = 1'b1, en_b = 1'b0;
  logic hs_b, vs_b, de_b, req_b, ls_b, fs_b;
  logic [11:0] px_b, py_b;
  logic [7:0] fc_b;
  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1), .CW(12)
  ) dut_b (
    .vga_clk(clk), .rst(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .pix_x(px_b), .pix_y(py_b), .req(req_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b));

  // Long-lead mode: REQ_LEAD equals H_BACK = 48
  logic rst_c = 1'b1, en_c = 1'b0;
  logic hs_c, vs_c, de_c, req_c, ls_c, fs_c;
  logic [11:0] px_c, py_c;
  logic [7:0] fc_c;
  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(48), .H_ACTIVE(8), .H_FRONT(4),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(48), .CW(12)
  ) dut_c (
    .vga_clk(clk), .rst(rst_c), .en(en_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .pix_x(px_c), .pix_y(py_c), .req(req_c), .line_start(ls_c), .frame_start(fs_c),
    .frame_cnt(fc_c));

  typedef struct {
    int          k;
    logic        hs, vs, de, req, ls, fs;
    logic [11:0] px, py;
    logic [7:0]  fc;
  } vec_t;

  localparam int NV = 12;
  vec_t tv [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int e, nfs, first_de, first_req, hlow, vlow, pixbad;
    int req_rise, req_fall, de_rise, req_n, de_n;
    logic pde, preq;

    //              k  hs vs de rq ls fs px py fc
    tv[0]  = '{ 1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    tv[1]  = '{ 2, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[2]  = '{ 3, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[3]  = '{ 9, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    tv[4]  = '{19, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[5]  = '{20, 0, 0, 1, 1, 0, 0, 0, 0, 1};
    tv[6]  = '{23, 0, 0, 1, 0, 0, 0, 3, 0, 1};
    tv[7]  = '{24, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[8]  = '{36, 0, 0, 1, 1, 0, 0, 0, 2, 1};
    tv[9]  = '{39, 0, 0, 1, 0, 0, 0, 3, 2, 1};
    tv[10] = '{44, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tv[11] = '{49, 1, 1, 0, 0, 1, 1, 0, 0, 2};

    repeat (3) tick();
    check("reset_a", {hs_a, vs_a, de_a, req_a, ls_a, fs_a, px_a, py_a, fc_a},
          {1'b1, 1'b1, 4'b0, 12'd0, 12'd0, 8'd0});
    check("reset_b", {hs_b, vs_b, de_b, req_b, ls_b, fs_b, px_b, py_b, fc_b},
          {1'b0, 1'b0, 4'b0, 12'd0, 12'd0, 8'd0});

    // ---------------- small mode: vector table ----------------
    en_b = 1'b1;
    rst_b = 1'b0;
    e = 0;
    for (int i = 0; i < NV; i++) begin
      while (e < tv[i].k) begin
        tick();
        e++;
      end
      check($sformatf("small_vec_k%0d", tv[i].k),
            {hs_b, vs_b, de_b, req_b, ls_b, fs_b, px_b, py_b, fc_b},
            {tv[i].hs, tv[i].vs, tv[i].de, tv[i].req, tv[i].ls, tv[i].fs,
             tv[i].px, tv[i].py, tv[i].fc});
    end

    // frame_cnt wrap: frame n starts at edge 1+48*(n-1)
    nfs = 0;
    while (e < 12289) begin
      tick();
      e++;
      if (fs_b) nfs++;
      if (e == 12241) check("fc_wrap_256", {fs_b, fc_b}, {1'b1, 8'd0});
    end
    check("fc_after_wrap", {fs_b, fc_b}, {1'b1, 8'd1});
    check("fs_count_b", nfs, 255);

    // en dropped mid-frame: frame completes, then idle
    while (e < 12300) begin tick(); e++; end
    en_b = 1'b0;
    while (e < 12336) begin tick(); e++; end
    check("drain_last_pos", {hs_b, vs_b, de_b, fs_b}, {4'b0000});
    tick(); e++;
    check("idle_after_drain", {hs_b, vs_b, de_b, req_b, ls_b, fs_b, px_b, py_b, fc_b},
          {6'b0, 12'd0, 12'd0, 8'd1});
    while (e < 12340) begin tick(); e++; end
    check("idle_held", {hs_b, vs_b, de_b, ls_b, fs_b, fc_b}, {5'b0, 8'd1});
    en_b = 1'b1;
    tick(); e++;
    check("restart_b", {hs_b, vs_b, ls_b, fs_b, fc_b}, {4'b1111, 8'd2});

    // short en pulse low mid-frame: next frame starts without a gap
    nfs = 0;
    while (e < 12388) begin
      tick();
      e++;
      if (e == 12351) en_b = 1'b0;
      if (e == 12361) en_b = 1'b1;
      if (fs_b) nfs++;
    end
    check("no_fs_in_pulse_frame", nfs, 0);
    tick(); e++;
    check("fs_no_gap", {fs_b, fc_b}, {1'b1, 8'd3});

    // ---------------- long-lead mode ----------------
    en_c = 1'b1;
    rst_c = 1'b0;
    e = 0; pde = 1'b0; preq = 1'b0;
    req_rise = -1000; req_fall = -1000; de_rise = 0; req_n = 0; de_n = 0;
    while (e < 320) begin
      tick();
      e++;
      if (req_c) req_n++;
      if (de_c) de_n++;
      if (req_c && !preq) req_rise = e;
      if (!req_c && preq) req_fall = e;
      if (de_c && !pde) begin
        de_rise = e;
        check("lead48_offset", e - req_rise, 48);
      end
      if (!de_c && pde) check("lead48_runlen", e - de_rise, req_fall - req_rise);
      pde = de_c;
      preq = req_c;
    end
    check("lead48_req_cycles", req_n, 16);
    check("lead48_de_cycles", de_n, 16);

    // ---------------- default mode ----------------
    en_a = 1'b1;
    rst_a = 1'b0;
    e = 0; first_de = 0; first_req = 0; hlow = 0; vlow = 0; pixbad = 0;
    while (e < 30000) begin
      tick();
      e++;
      if (e == 1) check("dflt_edge1", {fs_a, ls_a, hs_a, vs_a, de_a, fc_a}, {5'b11000, 8'd1});
      if (de_a && first_de == 0) first_de = e;
      if (req_a && first_req == 0) first_req = e;
      if (!de_a && (px_a != 0 || py_a != 0)) pixbad++;
      if (e <= 800 && !hs_a) hlow++;
      if (e <= 2000 && !vs_a) vlow++;
      if (e == 28145) check("pix_first", {de_a, px_a, py_a}, {1'b1, 12'd0, 12'd0});
      if (e == 28784) check("pix_line_end", {de_a, px_a, py_a}, {1'b1, 12'd639, 12'd0});
      if (e == 28785) check("de_off_after_line", {de_a, px_a, py_a}, {1'b0, 12'd0, 12'd0});
      if (e == 28945) check("pix_line1", {de_a, px_a, py_a}, {1'b1, 12'd0, 12'd1});
      if (e == 30000) check("pix_e30000", {hs_a, de_a, px_a, py_a}, {2'b11, 12'd255, 12'd2});
    end
    check("first_de_edge", first_de, 28145);
    check("first_req_edge", first_req, 28143);
    check("hsync_low_per_line", hlow, 96);
    check("vsync_low_cycles", vlow, 1600);
    check("pix_zero_when_no_de", pixbad, 0);

    // asynchronous reset between clock edges
    #1 rst_a = 1'b1;
    #2;
    check("async_reset", {hs_a, vs_a, de_a, req_a, ls_a, fs_a, px_a, py_a, fc_a},
          {1'b1, 1'b1, 4'b0, 12'd0, 12'd0, 8'd0});
    #2 rst_a = 1'b0;
    tick();
    check("after_reset_edge1", {fs_a, ls_a, hs_a, vs_a, fc_a}, {4'b1100, 8'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
